vpu_sram_rd_port_responder: RTL and testbench
=============================================

// Module: vpu_sram_rd_port_responder
// PURPOSE
//  SRAM-side responder for the SRAM_R_PORT_IF read protocol. Serves the VPU source port controllers.
//  - Accepts one read request per ack handshake and issues it to the selected SRAM bank.
//  - Tracks in-flight reads through a fixed-latency return pipeline.
//  - Returns each read word to the host as a single-cycle rvalid/rdata pulse.
//  - Sits between one host read port and the SRAM bank array/arbiter inside SRAM_INCT.
// PARAMETERS
//  SRAM_BANK_CNT        4    number of SRAM banks
//  SRAM_BANK_CNT_LG2    2    width of rid
//  SRAM_BANK_DEPTH_LG2  10   width of per-bank word address
//  SRAM_DATA_WIDTH      256  data word width
//  RD_LATENCY           1    bank read latency: cycles from csb low to bank_rdata_i valid (>=1)
//  MAX_OUTSTANDING      2    max accepted-but-not-returned reads (1..4)
// PORTS
//  clk           in   1                             clock
//  rst           in   1                             asynchronous, active-high reset
//  rd_req_i      in   1                             host request (SRAM_R_PORT_IF.req)
//  rd_rid_i      in   SRAM_BANK_CNT_LG2             target bank id
//  rd_addr_i     in   SRAM_BANK_DEPTH_LG2           word address in bank
//  rd_reb_i      in   1                             read enable, active-low
//  rd_rlast_i    in   1                             last beat of burst
//  rd_ack_o      out  1                             request accepted this cycle
//  rd_rvalid_o   out  1                             rdata valid, 1-cycle pulse per accepted read
//  rd_rdata_o    out  SRAM_DATA_WIDTH               returned read word
//  bank_busy_i   in   SRAM_BANK_CNT                 bank in use by another port; do not issue
//  bank_csb_o    out  SRAM_BANK_CNT                 per-bank chip select, active-low
//  bank_addr_o   out  SRAM_BANK_DEPTH_LG2           shared bank address
//  bank_rdata_i  in   SRAM_BANK_CNT*SRAM_DATA_WIDTH bank read data; bank k at [k*W +: W]
//  bank_lock_o   out  SRAM_BANK_CNT                 burst lock held on a bank
// BEHAVIOUR
//  - Reset (async, rst=1): all outputs 0, except bank_csb_o, which is all 1s.
//    Pipeline, counter, lock and FSM are cleared.
//    In-flight reads are dropped; no rvalid is issued for them after release.
//  - Accept (combinational): ack = req & ~reb & ~bank_busy_i[rid] & (cnt<MAX_OUTSTANDING | ret_now) & lock_ok.
//    - ret_now: a read returns (rvalid) in the same cycle.
//    - lock_ok: true when no lock is held, or when rid equals the locked bank.
//  - ack is evaluated every cycle. The host drops req the cycle after ack, so each beat is acked exactly once.
//  - req with reb=1: ignored, no ack, no bank access.
//  - Issue: for a read accepted at cycle t, at t+1 bank_csb_o[rid]=0 (others 1) and bank_addr_o=addr.
//    At most one bank is selected per cycle.
//  - Return pipeline: RD_LATENCY-deep shift register of {valid, rid}.
//    At t+1+RD_LATENCY the word is selected as bank_rdata_i[rid].
//  - Latency, accept to rvalid: RD_LATENCY+2 cycles with SRAM_RD_OUT_REG_EN defined, otherwise RD_LATENCY+1.
//  - Reads return in order. rvalid rises exactly once per ack. Back-to-back acks give back-to-back rvalids.
//  - Outstanding counter cnt:
//    - +1 on ack, -1 on rvalid.
//    - Unchanged when ack and rvalid occur in the same cycle.
//    - Never exceeds MAX_OUTSTANDING and never underflows.
//  - FSM, with state registered from the next-state values:
//    - S_IDLE (cnt==0, no lock) -> S_ACTIVE on ack.
//    - S_ACTIVE -> S_FULL when cnt reaches MAX_OUTSTANDING.
//    - S_FULL -> S_ACTIVE on rvalid.
//    - S_ACTIVE -> S_IDLE when cnt==0 and no lock.
//    - Acks are never issued in S_FULL, except in the same cycle as a return.
//  - Burst lock:
//    - An acked beat with rlast=0 sets bank_lock_o[rid]=1 from t+1.
//    - The acked beat with rlast=1 clears it from t+1.
//    - While locked, a request to a different rid is not acked and stalls until the lock is released.
//    - A single read (rlast=1, no lock) never sets a lock.
//  - bank_busy_i does not affect issue or return of already-accepted reads.
//  - rd_rdata_o holds its last value when rvalid=0 (registered build). In the unregistered build it is don't-care.
// CONFIGURATION
//  SRAM_RD_OUT_REG_EN defined:
//   - rd_rvalid_o and rd_rdata_o come from flops.
//   - Latency is RD_LATENCY+2.
//   - ret_now refers to the registered rvalid.
//  Not defined:
//   - rvalid and rdata are driven combinationally from the last pipeline stage and the bank_rdata_i mux.
//   - Latency is RD_LATENCY+1. All other behaviour is identical.
// TESTING (RD_LATENCY=1, MAX_OUTSTANDING=2, SRAM_RD_OUT_REG_EN defined unless noted)
//  1. Single read: req, rid=2, addr=0x005, reb=0, rlast=1 at t; bank2 returns 0xA5A5..A5.
//     -> ack at t; bank_csb_o=4'b1011 and addr=0x005 at t+1; rvalid=1 at t+3 for one cycle; rdata=0xA5A5..A5.
//  2. Three reads to rids 0, 1, 2 at t, t+1, t+2.
//     -> acks at t and t+1; third ack withheld until t+3, coinciding with the first rvalid.
//     -> rvalids at t+3, t+4, t+6, in order.
//  3. bank_busy_i[1]=1 for cycles t..t+3; req rid=1 held from t.
//     -> no ack during t..t+3; ack at t+4; no bank_csb_o[1] low before t+5.
//  4. Burst: rid=3 beats with rlast=0,0,1, plus an interleaved req rid=0 after beat 1.
//     -> bank_lock_o[3]=1 from the cycle after beat 1 until the cycle after beat 3 is acked.
//     -> rid=0 is not acked until the lock clears.
//  5. rst=1 asynchronously with 2 reads in flight.
//     -> outputs are at reset values within the same cycle; after release, no rvalid for 5 cycles; cnt=0, FSM=S_IDLE.
//  6. req=1 with reb=1 for 3 cycles -> no ack, bank_csb_o stays all 1s.
//     Repeat test 1 with SRAM_RD_OUT_REG_EN undefined -> rvalid at t+2.

Source files
------------

// File: rtl/vpu_sram_rd_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sram_rd_port_responder_if
// Description : SRAM read-port handshake bundle between a host source port
//               controller (master) and the SRAM-side responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vpu_sram_rd_port_responder_if #(
    parameter int SRAM_BANK_CNT_LG2   = 2,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 256
);
    logic                           req;
    logic [SRAM_BANK_CNT_LG2-1:0]   rid;
    logic [SRAM_BANK_DEPTH_LG2-1:0] addr;
    logic                           reb;
    logic                           rlast;
    logic                           ack;
    logic                           rvalid;
    logic [SRAM_DATA_WIDTH-1:0]     rdata;

    // Host side: issues requests, observes accept and returned data
    modport master (
        output req, rid, addr, reb, rlast,
        input  ack, rvalid, rdata
    );

    // Responder side
    modport slave (
        input  req, rid, addr, reb, rlast,
        output ack, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/vpu_sram_rd_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sram_rd_port_responder
// Description : SRAM-side responder for one host read port. Accepts one read
//               per ack, issues it to the selected bank the next cycle, tracks
//               it through a fixed-latency return pipeline and returns the word
//               as a single-cycle rvalid/rdata pulse. Supports burst locking.
// Config      : define SRAM_RD_OUT_REG_EN to register rvalid/rdata (+1 cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_sram_rd_port_responder #(
    parameter int SRAM_BANK_CNT       = 4,
    parameter int SRAM_BANK_CNT_LG2   = 2,
    parameter int SRAM_BANK_DEPTH_LG2 = 10,
    parameter int SRAM_DATA_WIDTH     = 256,
    parameter int RD_LATENCY          = 1,
    parameter int MAX_OUTSTANDING     = 2
) (
    input  wire logic                                     clk,
    input  wire logic                                     rst,
    vpu_sram_rd_port_responder_if.slave                   rd_if,
    input  wire logic [SRAM_BANK_CNT-1:0]                 bank_busy_i,
    output logic      [SRAM_BANK_CNT-1:0]                 bank_csb_o,
    output logic      [SRAM_BANK_DEPTH_LG2-1:0]           bank_addr_o,
    input  wire logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0] bank_rdata_i,
    output logic      [SRAM_BANK_CNT-1:0]                 bank_lock_o
);
    localparam int                C_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [C_CNT_W-1:0] C_MAX_OUT = C_CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [C_CNT_W-1:0]               cnt_q, cnt_d;
    logic                             lock_vld_q, lock_vld_d;
    logic [SRAM_BANK_CNT_LG2-1:0]     lock_rid_q, lock_rid_d;
    logic                             iss_vld_q;
    logic [SRAM_BANK_CNT_LG2-1:0]     iss_rid_q;
    logic [SRAM_BANK_DEPTH_LG2-1:0]   iss_addr_q;
    logic [RD_LATENCY-1:0]                        pipe_vld_q;
    logic [RD_LATENCY-1:0][SRAM_BANK_CNT_LG2-1:0] pipe_rid_q;

    logic [SRAM_BANK_CNT-1:0][SRAM_DATA_WIDTH-1:0] w_banks;
    logic                             w_last_vld;
    logic [SRAM_BANK_CNT_LG2-1:0]     w_last_rid;
    logic [SRAM_DATA_WIDTH-1:0]       w_bank_word;
    logic                             w_rvalid;
    logic [SRAM_DATA_WIDTH-1:0]       w_rdata;
    logic                             w_ack;
    logic                             w_lock_ok;
    logic                             w_room;

    assign w_banks     = bank_rdata_i;
    assign w_last_vld  = pipe_vld_q[RD_LATENCY-1];
    assign w_last_rid  = pipe_rid_q[RD_LATENCY-1];
    assign w_bank_word = w_banks[w_last_rid];

`ifdef SRAM_RD_OUT_REG_EN
    logic                       rvalid_q;
    logic [SRAM_DATA_WIDTH-1:0] rdata_q;

    // Output register: one-cycle rvalid pulse, rdata held between returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= w_last_vld;
            if (w_last_vld) rdata_q <= w_bank_word;
        end
    end

    assign w_rvalid = rvalid_q;
    assign w_rdata  = rdata_q;
`else
    assign w_rvalid = w_last_vld;
    assign w_rdata  = w_last_vld ? w_bank_word : '0;
`endif

    // A return in this cycle frees a slot, so a new read may be taken at the limit.
    // The FULL-state term is redundant with the counter but keeps the FSM authoritative.
    assign w_lock_ok = ~lock_vld_q | (rd_if.rid == lock_rid_q);
    assign w_room    = ((cnt_q < C_MAX_OUT) & (state_q != S_FULL)) | w_rvalid;
    assign w_ack     = ~rst & rd_if.req & ~rd_if.reb & ~bank_busy_i[rd_if.rid]
                       & w_room & w_lock_ok;

    assign rd_if.ack    = w_ack;
    assign rd_if.rvalid = w_rvalid;
    assign rd_if.rdata  = w_rdata;

    assign bank_csb_o  = ~(iss_vld_q ? (SRAM_BANK_CNT'(1) << iss_rid_q) : '0);
    assign bank_addr_o = iss_addr_q;
    assign bank_lock_o = lock_vld_q ? (SRAM_BANK_CNT'(1) << lock_rid_q) : '0;

    // Next-state: outstanding count, burst lock and FSM
    always_comb begin
        cnt_d      = cnt_q + C_CNT_W'(w_ack) - C_CNT_W'(w_rvalid);
        lock_vld_d = lock_vld_q;
        lock_rid_d = lock_rid_q;
        state_d    = state_q;
        if (w_ack) begin
            lock_vld_d = ~rd_if.rlast;
            lock_rid_d = rd_if.rid;
        end
        case (state_q)
            S_IDLE: begin
                if (w_ack) state_d = (cnt_d == C_MAX_OUT) ? S_FULL : S_ACTIVE;
            end
            S_ACTIVE: begin
                if (cnt_d == C_MAX_OUT)                 state_d = S_FULL;
                else if ((cnt_d == '0) && !lock_vld_d)  state_d = S_IDLE;
            end
            S_FULL: begin
                if (w_rvalid && (cnt_d != C_MAX_OUT))
                    state_d = ((cnt_d == '0) && !lock_vld_d) ? S_IDLE : S_ACTIVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_rid_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lock_vld_q <= lock_vld_d;
            lock_rid_q <= lock_rid_d;
        end
    end

    // Issue stage: drive the accepted read to its bank one cycle after ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_vld_q  <= 1'b0;
            iss_rid_q  <= '0;
            iss_addr_q <= '0;
        end else begin
            iss_vld_q <= w_ack;
            if (w_ack) begin
                iss_rid_q  <= rd_if.rid;
                iss_addr_q <= rd_if.addr;
            end
        end
    end

    // Return pipeline: last stage lines up with bank_rdata_i of the issued bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            pipe_rid_q <= '0;
        end else begin
            pipe_vld_q[0] <= iss_vld_q;
            pipe_rid_q[0] <= iss_rid_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_rid_q[i] <= pipe_rid_q[i-1];
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vpu_sram_rd_port_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpu_sram_rd_port_responder
// Description : Self-checking bench for vpu_sram_rd_port_responder with a
//               queue-based reference model, a vector table, directed corner
//               sequences and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vpu_sram_rd_port_responder;
    localparam int RD_LAT  = 1;
    localparam int MAX_OUT = 2;
`ifdef SRAM_RD_OUT_REG_EN
    localparam int LAT = RD_LAT + 2;
    localparam bit REG = 1'b1;
`else
    localparam int LAT = RD_LAT + 1;
    localparam bit REG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   bank_busy = '0;
    logic [3:0]   bank_csb;
    logic [9:0]   bank_addr;
    logic [1023:0] bank_rdata;
    logic [3:0]   bank_lock;
    int           cyc = 0;
    bit           a5_mode = 1'b0;
    int           checks = 0;
    int           failures = 0;

    vpu_sram_rd_port_responder_if #(.SRAM_BANK_CNT_LG2(2), .SRAM_BANK_DEPTH_LG2(10),
                                    .SRAM_DATA_WIDTH(256)) rd_if ();

    vpu_sram_rd_port_responder #(
        .SRAM_BANK_CNT(4), .SRAM_BANK_CNT_LG2(2), .SRAM_BANK_DEPTH_LG2(10),
        .SRAM_DATA_WIDTH(256), .RD_LATENCY(RD_LAT), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk), .rst(rst), .rd_if(rd_if),
        .bank_busy_i(bank_busy), .bank_csb_o(bank_csb), .bank_addr_o(bank_addr),
        .bank_rdata_i(bank_rdata), .bank_lock_o(bank_lock)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each bank presents a word tagged with bank id and the current cycle
    function automatic logic [255:0] bank_word(input int k, input int c, input bit a5);
        if (a5) return {32{8'hA5}};
        return {8{8'(k), 8'hC3, 16'(c)}};
    endfunction

    assign bank_rdata = {bank_word(3, cyc, a5_mode), bank_word(2, cyc, a5_mode),
                         bank_word(1, cyc, a5_mode), bank_word(0, cyc, a5_mode)};

    // Reference model state: reads in flight with their due cycle and word
    typedef struct { int due; logic [255:0] data; } pend_t;
    pend_t       pq[$];
    bit          m_iss = 0;
    logic [1:0]  m_iss_rid = '0;
    logic [9:0]  m_iss_addr = '0;
    bit          m_lock = 0;
    logic [1:0]  m_lock_rid = '0;

    logic         last_ack, last_rvalid;
    logic [3:0]   last_csb, last_lock;
    logic [255:0] last_rdata;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic step(input bit req, input bit reb, input bit rlast, input logic [1:0] rid,
                        input logic [9:0] addr, input logic [3:0] busy);
        bit           due_now, lock_ok, e_ack;
        logic [3:0]   e_csb, e_lock;
        @(posedge clk);
        #1;
        rd_if.req = req; rd_if.reb = reb; rd_if.rlast = rlast;
        rd_if.rid = rid; rd_if.addr = addr; bank_busy = busy;
        #1;
        due_now = (pq.size() > 0) && (pq[0].due == cyc);
        lock_ok = !m_lock || (rid == m_lock_rid);
        e_ack   = req && !reb && !busy[rid] && lock_ok && ((pq.size() < MAX_OUT) || due_now);
        e_csb   = m_iss ? ~(4'b0001 << m_iss_rid) : 4'hF;
        e_lock  = m_lock ? (4'b0001 << m_lock_rid) : 4'h0;
        last_ack = rd_if.ack; last_rvalid = rd_if.rvalid; last_rdata = rd_if.rdata;
        last_csb = bank_csb;  last_lock = bank_lock;
        chk("ack", {255'b0, rd_if.ack}, {255'b0, e_ack});
        chk("rvalid", {255'b0, rd_if.rvalid}, {255'b0, due_now});
        chk("csb", {252'b0, bank_csb}, {252'b0, e_csb});
        chk("lock", {252'b0, bank_lock}, {252'b0, e_lock});
        if (due_now) chk("rdata", rd_if.rdata, pq[0].data);
        if (m_iss) chk("bank_addr", {246'b0, bank_addr}, {246'b0, m_iss_addr});
        if (due_now) void'(pq.pop_front());
        m_iss = e_ack; m_iss_rid = rid; m_iss_addr = addr;
        if (e_ack) begin
            pq.push_back('{due: cyc + LAT, data: bank_word(int'(rid), cyc + 1 + RD_LAT, a5_mode)});
            m_lock = !rlast;
            m_lock_rid = rid;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 2'd0, 10'd0, 4'h0);
    endtask

    typedef struct { bit req; bit reb; logic [1:0] rid; logic [3:0] busy; bit exp_ack; } vec_t;
    vec_t tbl[8];

    logic [15:0] ack_m, rv_m, aux_m;
    bit          got;
    logic [255:0] rd_seen;

    initial begin
        rd_if.req = 0; rd_if.reb = 1; rd_if.rlast = 1; rd_if.rid = '0; rd_if.addr = '0;
        tbl[0] = '{1, 0, 2'd2, 4'h0, 1};
        tbl[1] = '{1, 1, 2'd2, 4'h0, 0};
        tbl[2] = '{0, 0, 2'd1, 4'h0, 0};
        tbl[3] = '{1, 0, 2'd1, 4'h2, 0};
        tbl[4] = '{1, 0, 2'd1, 4'hD, 1};
        tbl[5] = '{1, 0, 2'd3, 4'h8, 0};
        tbl[6] = '{1, 0, 2'd0, 4'hE, 1};
        tbl[7] = '{1, 0, 2'd3, 4'h7, 1};

        // Reset values
        #1;
        chk("rst_csb", {252'b0, bank_csb}, {252'b0, 4'hF});
        chk("rst_ack", {255'b0, rd_if.ack}, 256'd0);
        chk("rst_rvalid", {255'b0, rd_if.rvalid}, 256'd0);
        chk("rst_lock", {252'b0, bank_lock}, 256'd0);
        chk("rst_rdata", rd_if.rdata, 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Vector table from an idle responder
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].req, tbl[i].reb, 1, tbl[i].rid, 10'(i * 7), tbl[i].busy);
            chk($sformatf("tbl%0d_ack", i), {255'b0, last_ack}, {255'b0, tbl[i].exp_ack});
            idle(6);
        end

        // Single read to bank 2
        a5_mode = 1;
        step(1, 0, 1, 2'd2, 10'h005, 4'h0);
        chk("t1_ack", {255'b0, last_ack}, 256'd1);
        rv_m = '0; rd_seen = '0;
        for (int k = 1; k < 8; k++) begin
            step(0, 0, 1, 2'd0, 10'd0, 4'h0);
            if (k == 1) begin
                chk("t1_csb", {252'b0, last_csb}, {252'b0, 4'b1011});
                chk("t1_addr", {246'b0, bank_addr}, {246'b0, 10'h005});
            end
            if (last_rvalid) begin rv_m[k] = 1; rd_seen = last_rdata; end
        end
        chk("t1_rvalid_cycle", {240'b0, rv_m}, REG ? 256'h8 : 256'h4);
        chk("t1_rdata", rd_seen, {32{8'hA5}});
        a5_mode = 0;
        idle(4);

        // Three back-to-back reads, third waits for a free slot
        ack_m = '0; rv_m = '0; got = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      step(1, 0, 1, 2'd0, 10'h010, 4'h0);
            else if (k == 1) step(1, 0, 1, 2'd1, 10'h011, 4'h0);
            else if (!got)   step(1, 0, 1, 2'd2, 10'h012, 4'h0);
            else             step(0, 0, 1, 2'd0, 10'h000, 4'h0);
            if (last_ack) begin ack_m[k] = 1; if (k >= 2) got = 1; end
            if (last_rvalid) rv_m[k] = 1;
        end
        chk("t2_acks", {240'b0, ack_m}, REG ? 256'h00B : 256'h007);
        chk("t2_rvalids", {240'b0, rv_m}, REG ? 256'h058 : 256'h01C);

        // Busy bank holds off acceptance
        ack_m = '0; aux_m = '0; got = 0;
        for (int k = 0; k < 10; k++) begin
            if (!got) step(1, 0, 1, 2'd1, 10'h0AA, (k <= 3) ? 4'h2 : 4'h0);
            else      step(0, 0, 1, 2'd0, 10'h000, 4'h0);
            if (last_ack) begin ack_m[k] = 1; got = 1; end
            if (!last_csb[1]) aux_m[k] = 1;
        end
        chk("t3_acks", {240'b0, ack_m}, 256'h010);
        chk("t3_csb1_low", {240'b0, aux_m}, 256'h020);
        idle(4);

        // Burst on bank 3 with an interleaved request to bank 0
        ack_m = '0; aux_m = '0; got = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)      step(1, 0, 0, 2'd3, 10'h100, 4'h0);
            else if (k == 1) step(1, 0, 1, 2'd0, 10'h200, 4'h0);
            else if (k == 2) step(1, 0, 0, 2'd3, 10'h101, 4'h0);
            else if (k == 3) step(1, 0, 1, 2'd3, 10'h102, 4'h0);
            else if (!got)   step(1, 0, 1, 2'd0, 10'h200, 4'h0);
            else             step(0, 0, 1, 2'd0, 10'h000, 4'h0);
            if (last_ack) begin ack_m[k] = 1; if (k >= 4) got = 1; end
            if (last_lock[3]) aux_m[k] = 1;
        end
        chk("t4_acks", {240'b0, ack_m}, REG ? 256'h02D : 256'h01D);
        chk("t4_lock3", {240'b0, aux_m}, 256'h00E);
        idle(4);

        // Asynchronous reset with two reads in flight
        step(1, 0, 1, 2'd0, 10'h300, 4'h0);
        step(1, 0, 1, 2'd1, 10'h301, 4'h0);
        step(0, 0, 1, 2'd0, 10'h000, 4'h0);
        #1;
        rst = 1;
        rd_if.req = 1; rd_if.reb = 0; rd_if.rid = 2'd3;
        #1;
        chk("t5_ack", {255'b0, rd_if.ack}, 256'd0);
        chk("t5_rvalid", {255'b0, rd_if.rvalid}, 256'd0);
        chk("t5_csb", {252'b0, bank_csb}, {252'b0, 4'hF});
        chk("t5_lock", {252'b0, bank_lock}, 256'd0);
        chk("t5_rdata", rd_if.rdata, 256'd0);
        pq.delete(); m_iss = 0; m_lock = 0;
        @(posedge clk);
        #1;
        rst = 0; rd_if.req = 0;
        rv_m = '0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 2'd0, 10'd0, 4'h0);
            if (last_rvalid) rv_m[k] = 1;
        end
        chk("t5_no_rvalid", {240'b0, rv_m}, 256'd0);
        ack_m = '0;
        step(1, 0, 1, 2'd2, 10'h020, 4'h0); ack_m[0] = last_ack;
        step(1, 0, 1, 2'd3, 10'h021, 4'h0); ack_m[1] = last_ack;
        chk("t5_post_acks", {240'b0, ack_m}, 256'h3);
        idle(6);

        // reb high: requests ignored, no bank access
        ack_m = '0; aux_m = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) step(1, 1, 1, 2'(k), 10'h3FF, 4'h0);
            else       step(0, 0, 1, 2'd0, 10'h000, 4'h0);
            if (last_ack) ack_m[k] = 1;
            if (last_csb != 4'hF) aux_m[k] = 1;
        end
        chk("t6_acks", {240'b0, ack_m}, 256'd0);
        chk("t6_csb_idle", {240'b0, aux_m}, 256'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom), 10'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
